// File: rtl/traffic_pkg.sv
// traffic_pkg: types and constants shared by the junction lights and the pedestrian crossing.
//   ped_state_t      pedestrian controller FSM state
//   LAMP_*           vehicle lamp patterns as {red, amber, green}
//   DEF_*_CYCLES     default timing for pedestrian_crossing
//   PED_CNT_W        width of all pedestrian-side counters
package traffic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWalk,
    StClear,
    StGap
  } ped_state_t;

  // Lamp patterns, bit order {red, amber, green}.
  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_WALK_CYCLES     = 5;
  localparam int unsigned DEF_CLEAR_CYCLES    = 4;
  localparam int unsigned DEF_GAP_CYCLES      = 8;

  localparam int unsigned PED_CNT_W = 8;

  // Vehicles held: red lit, amber and green dark.
  function automatic logic lamps_red_only(input logic [2:0] lamps);
    return lamps == LAMP_RED;
  endfunction

  // Green lit together with red or amber can never come from a healthy junction.
  function automatic logic lamps_conflict(input logic [2:0] lamps);
    return ((lamps & LAMP_GREEN) != 3'b000) && ((lamps & LAMP_RED_AMBER) != 3'b000);
  endfunction

  // Terminal count for a phase lasting 'cycles' clock cycles (counter starts at 0).
  function automatic logic [PED_CNT_W-1:0] cnt_last(input int unsigned cycles);
    return PED_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: conditions the raw pedestrian push button.
//   A 2-flop synchronizer feeds a debounce counter; the debounced level only changes after
//   DEBOUNCE_CYCLES consecutive synchronized samples differ from it. press_o is a one-cycle
//   combinational pulse on the edge where the debounced level rises, so a consumer that
//   registers on the same edge sees the press with no extra latency.
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   button_raw_i  raw, asynchronous button level
//   press_o       accepted rising edge of the debounced level
module button_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_raw_i,
  output logic press_o
);

  localparam logic [PED_CNT_W-1:0] CntLast = cnt_last(DEBOUNCE_CYCLES);

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic [PED_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any agreeing sample
  // restarts the count, so short glitches never reach the terminal value.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_o = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        press_o = sync2_q;
      end else begin
        cnt_d = cnt_q + PED_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pedestrian_crossing.sv
// pedestrian_crossing: pedestrian-side controller for the crossing served by traffic_light.
//   Debounces the push button, raises ped_request_o towards traffic_light and sequences
//   WALK / flashing DON'T WALK / solid DON'T WALK, only showing WALK while the returned
//   vehicle lamps are red-only. All outputs are registered.
// Build option:
//   PED_FAULT_DETECT_EN  when defined, a lamp conflict (green with red/amber, or green/amber
//                        seen during WALK) sets the sticky fault_o and parks the FSM in GAP.
//                        When undefined, fault_o is tied low.
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   button_raw_i   raw pedestrian push button
//   red_i          vehicle red lamp (traffic_light red_o)
//   amber_i        vehicle amber lamp (traffic_light amber_o)
//   green_i        vehicle green lamp (traffic_light green_o)
//   ped_request_o  request to traffic_light pedestrian_button_i
//   walk_o         WALK signal
//   dont_walk_o    DON'T WALK signal, solid or flashing
//   wait_lamp_o    request-registered indicator
//   fault_o        sticky lamp/WALK conflict flag
module pedestrian_crossing
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int unsigned CLEAR_CYCLES    = DEF_CLEAR_CYCLES,
  parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_raw_i,
  input  logic red_i,
  input  logic amber_i,
  input  logic green_i,
  output logic ped_request_o,
  output logic walk_o,
  output logic dont_walk_o,
  output logic wait_lamp_o,
  output logic fault_o
);

  localparam logic [PED_CNT_W-1:0] WalkLast  = cnt_last(WALK_CYCLES);
  localparam logic [PED_CNT_W-1:0] ClearLast = cnt_last(CLEAR_CYCLES);
  localparam logic [PED_CNT_W-1:0] GapLast   = cnt_last(GAP_CYCLES);

  logic                 press;
  logic [2:0]           lamps;
  logic                 red_only;
  logic                 fault_hold;

  ped_state_t           state_q, state_d;
  logic [PED_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pending_q, pending_d;

  logic                 ped_request_d, walk_d, dont_walk_d, wait_lamp_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .button_raw_i (button_raw_i),
    .press_o      (press)
  );

  assign lamps    = {red_i, amber_i, green_i};
  assign red_only = lamps_red_only(lamps);

`ifdef PED_FAULT_DETECT_EN
  logic fault_q;
  logic fault_now;

  assign fault_now  = lamps_conflict(lamps) || ((state_q == StWalk) && (green_i || amber_i));
  // Holding on the detecting edge keeps WALK from being entered or extended on a bad sample.
  assign fault_hold = fault_q || fault_now;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_hold;
    end
  end

  assign fault_o = fault_q;
`else
  assign fault_hold = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // Next state. cnt_q counts cycles already spent in the current timed phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;

    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StRequest;
          cnt_d   = '0;
        end
      end
      StRequest: begin
        if (red_only) begin
          state_d = StWalk;
          cnt_d   = '0;
        end
      end
      StWalk: begin
        // Lamp loss and timer expiry on the same edge collapse into one exit.
        if (!red_only || (cnt_q == WalkLast)) begin
          state_d = StClear;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PED_CNT_W'(1);
        end
      end
      StClear: begin
        if (cnt_q == ClearLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PED_CNT_W'(1);
        end
      end
      StGap: begin
        if (press) begin
          pending_d = 1'b1;
        end
        if (cnt_q == GapLast) begin
          state_d   = (pending_q || press) ? StRequest : StIdle;
          pending_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + PED_CNT_W'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    if (fault_hold) begin
      state_d   = StGap;
      cnt_d     = '0;
      pending_d = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  always_comb begin
    ped_request_d = 1'b0;
    walk_d        = 1'b0;
    dont_walk_d   = 1'b1;
    wait_lamp_d   = 1'b0;
    unique case (state_d)
      StIdle: begin
      end
      StRequest: begin
        ped_request_d = 1'b1;
        wait_lamp_d   = 1'b1;
      end
      StWalk: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      StClear: begin
        // Flash starts lit on the first CLEAR cycle.
        dont_walk_d = ~cnt_d[0];
      end
      StGap: begin
        wait_lamp_d = pending_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      ped_request_o <= 1'b0;
      walk_o        <= 1'b0;
      dont_walk_o   <= 1'b1;
      wait_lamp_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      ped_request_o <= ped_request_d;
      walk_o        <= walk_d;
      dont_walk_o   <= dont_walk_d;
      wait_lamp_o   <= wait_lamp_d;
    end
  end

  // Pedestrian safety invariants.
  a_walk_excl : assert property (@(posedge clk_i) disable iff (rst_i) !(walk_o && dont_walk_o));
  a_walk_red  : assert property (@(posedge clk_i) disable iff (rst_i)
                                 (amber_i || green_i) |=> !walk_o);

endmodule

// File: tb/tb_pedestrian_crossing.sv
module tb_pedestrian_crossing;
  import traffic_pkg::*;

  localparam int DEB     = 4;
  localparam int WALK_C  = 5;
  localparam int CLEAR_C = 4;
  localparam int GAP_C   = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_REQ   = 1;
  localparam int PH_WALK  = 2;
  localparam int PH_CLEAR = 3;
  localparam int PH_GAP   = 4;

`ifdef PED_FAULT_DETECT_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  logic clk_i        = 1'b0;
  logic rst_i        = 1'b1;
  logic button_raw_i = 1'b0;
  logic red_i        = 1'b0;
  logic amber_i      = 1'b0;
  logic green_i      = 1'b1;
  logic ped_request_o, walk_o, dont_walk_o, wait_lamp_o, fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  pedestrian_crossing #(
    .DEBOUNCE_CYCLES (DEB),
    .WALK_CYCLES     (WALK_C),
    .CLEAR_CYCLES    (CLEAR_C),
    .GAP_CYCLES      (GAP_C)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .button_raw_i  (button_raw_i),
    .red_i         (red_i),
    .amber_i       (amber_i),
    .green_i       (green_i),
    .ped_request_o (ped_request_o),
    .walk_o        (walk_o),
    .dont_walk_o   (dont_walk_o),
    .wait_lamp_o   (wait_lamp_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: raw samples delayed two edges, a sliding window of the last DEB
  // synchronized samples, and phases timed by edge stamps.
  logic pipe_q[$];
  logic win_q[$];
  logic m_level, m_pending, m_fault;
  int   m_phase, m_cyc, m_enter;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    pipe_q.push_back(1'b0);
    pipe_q.push_back(1'b0);
    win_q.delete();
    for (int i = 0; i < DEB; i++) win_q.push_back(1'b0);
    m_level   = 1'b0;
    m_pending = 1'b0;
    m_fault   = 1'b0;
    m_phase   = PH_IDLE;
    m_cyc     = 0;
    m_enter   = 0;
  endtask

  task automatic enter(input int ph);
    m_phase = ph;
    m_enter = m_cyc;
  endtask

  task automatic model_step(input logic btn, input logic [2:0] lamps);
    logic seen, press, red_only, fault_now, dummy;
    int   ones, age;
    pipe_q.push_back(btn);
    seen = pipe_q.pop_front();
    win_q.push_back(seen);
    dummy = win_q.pop_front();
    ones = 0;
    foreach (win_q[i]) ones += int'(win_q[i]);
    press = 1'b0;
    if (!m_level && ones == DEB) begin
      m_level = 1'b1;
      press   = 1'b1;
    end else if (m_level && ones == 0) begin
      m_level = 1'b0;
    end
    m_cyc++;
    age       = m_cyc - m_enter;
    red_only  = (lamps == LAMP_RED);
    fault_now = FAULT_EN && ((lamps[0] && (lamps[2] || lamps[1])) ||
                             (m_phase == PH_WALK && (lamps[0] || lamps[1])));
    if (m_fault || fault_now) begin
      m_fault   = 1'b1;
      m_pending = 1'b0;
      enter(PH_GAP);
    end else begin
      case (m_phase)
        PH_IDLE:  if (press) enter(PH_REQ);
        PH_REQ:   if (red_only) enter(PH_WALK);
        PH_WALK:  if (age == WALK_C || !red_only) enter(PH_CLEAR);
        PH_CLEAR: if (age == CLEAR_C) enter(PH_GAP);
        default: begin
          if (press) m_pending = 1'b1;
          if (age == GAP_C) begin
            enter(m_pending ? PH_REQ : PH_IDLE);
            m_pending = 1'b0;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic btn, input logic [2:0] lamps);
    logic e_dont;
    button_raw_i = btn;
    {red_i, amber_i, green_i} = lamps;
    @(posedge clk_i);
    model_step(btn, lamps);
    #1;
    if (m_phase == PH_WALK)       e_dont = 1'b0;
    else if (m_phase == PH_CLEAR) e_dont = ((m_cyc - m_enter) % 2) == 0;
    else                          e_dont = 1'b1;
    check_eq("ped_request", ped_request_o, m_phase == PH_REQ);
    check_eq("walk", walk_o, m_phase == PH_WALK);
    check_eq("dont_walk", dont_walk_o, e_dont);
    check_eq("wait_lamp", wait_lamp_o, (m_phase == PH_REQ) || (m_phase == PH_GAP && m_pending));
    check_eq("fault", fault_o, m_fault);
    check_eq("walk_dont_excl", walk_o & dont_walk_o, 1'b0);
  endtask

  task automatic do_reset(input bit async_chk);
    if (async_chk) begin
      #2 rst_i = 1'b1;
      #1;
      check_eq("async_rst_walk", walk_o, 1'b0);
      check_eq("async_rst_dont_walk", dont_walk_o, 1'b1);
      check_eq("async_rst_ped_request", ped_request_o, 1'b0);
    end else begin
      rst_i = 1'b1;
    end
    button_raw_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("rst_ped_request", ped_request_o, 1'b0);
    check_eq("rst_walk", walk_o, 1'b0);
    check_eq("rst_dont_walk", dont_walk_o, 1'b1);
    check_eq("rst_wait_lamp", wait_lamp_o, 1'b0);
    check_eq("rst_fault", fault_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic       btn, seen_req;
    logic [2:0] lamps;
    int         btn_left, lamp_left, sel;

    // Clean press with lamps green, then a full WALK / CLEAR / GAP cycle on red.
    do_reset(1'b0);
    for (int e = 1; e <= 30; e++) begin
      step(e <= 7, (e >= 7) ? LAMP_RED : LAMP_GREEN);
      case (e)
        5: check_eq("lat_early", ped_request_o, 1'b0);
        6: begin
          check_eq("lat_req", ped_request_o, 1'b1);
          check_eq("lat_wait", wait_lamp_o, 1'b1);
        end
        7: begin
          check_eq("walk_entry", walk_o, 1'b1);
          check_eq("walk_entry_req", ped_request_o, 1'b0);
        end
        11: check_eq("walk_last", walk_o, 1'b1);
        12, 13, 14, 15: begin
          check_eq("clr_walk", walk_o, 1'b0);
          check_eq("clr_flash", dont_walk_o, logic'((e % 2) == 0));
        end
        16, 23, 30: check_eq("gap_solid", dont_walk_o, 1'b1);
        default: ;
      endcase
    end

    // 3-sample glitch must not be accepted.
    do_reset(1'b0);
    seen_req = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      step(e <= 3, LAMP_RED);
      seen_req = seen_req | ped_request_o | wait_lamp_o;
    end
    check_eq("glitch_no_req", seen_req, 1'b0);

    // Red already on at REQUEST entry; red+amber after two WALK cycles.
    do_reset(1'b0);
    for (int e = 1; e <= 24; e++) begin
      step(e <= 6, (e >= 9) ? LAMP_RED_AMBER : LAMP_RED);
      if (e == 6) check_eq("req_pulse", ped_request_o, 1'b1);
      if (e == 8) check_eq("early_walk_on", walk_o, 1'b1);
      if (e == 9) begin
        check_eq("early_walk_off", walk_o, 1'b0);
        check_eq("early_clear_start", dont_walk_o, 1'b1);
      end
    end

    // Reset asserted mid-WALK, then a normal cycle.
    do_reset(1'b0);
    for (int e = 1; e <= 8; e++) step(e <= 6, LAMP_RED);
    check_eq("pre_rst_walk", walk_o, 1'b1);
    do_reset(1'b1);
    for (int e = 1; e <= 30; e++) begin
      step(e <= 6, LAMP_RED);
      if (e == 7) check_eq("post_rst_walk", walk_o, 1'b1);
    end

    // Press during GAP.
    do_reset(1'b0);
    for (int e = 1; e <= 30; e++) begin
      step((e <= 6) || (e >= 16 && e <= 22), LAMP_RED);
      if (e == 20) check_eq("gap_wait_early", wait_lamp_o, 1'b0);
      if (e == 21) check_eq("gap_wait_set", wait_lamp_o, 1'b1);
      if (e == 23) check_eq("gap_req_held", ped_request_o, 1'b0);
      if (e == 24) check_eq("gap_req_rise", ped_request_o, 1'b1);
    end

    // Red+green conflict.
    do_reset(1'b0);
    for (int e = 1; e <= 16; e++) begin
      if (e == 2) lamps = 3'b101;
      else if (e < 8) lamps = LAMP_GREEN;
      else if (e < 12) lamps = LAMP_RED;
      else lamps = LAMP_AMBER;
      step(e <= 6, lamps);
      if (e == 2) check_eq("fault_set", fault_o, FAULT_EN);
      if (e == 10) check_eq("fault_dont_walk", dont_walk_o, FAULT_EN);
      if (e == 16) check_eq("fault_sticky", fault_o, FAULT_EN);
    end

    // Randomized traffic and button activity.
    do_reset(1'b0);
    btn       = 1'b0;
    lamps     = LAMP_GREEN;
    btn_left  = 0;
    lamp_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (btn_left == 0) begin
        btn      = logic'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 12);
      end
      if (lamp_left == 0) begin
        sel = $urandom_range(0, 15);
        if (sel < 7) begin
          lamps = LAMP_RED;        lamp_left = $urandom_range(3, 14);
        end else if (sel < 9) begin
          lamps = LAMP_RED_AMBER;  lamp_left = $urandom_range(1, 4);
        end else if (sel < 12) begin
          lamps = LAMP_GREEN;      lamp_left = $urandom_range(2, 10);
        end else if (sel < 14) begin
          lamps = LAMP_AMBER;      lamp_left = $urandom_range(1, 3);
        end else if (sel == 14) begin
          lamps = 3'b000;          lamp_left = $urandom_range(1, 2);
        end else begin
          lamps     = ($urandom_range(0, 9) == 0) ? 3'b101 : LAMP_RED;
          lamp_left = 1;
        end
      end
      btn_left--;
      lamp_left--;
      step(btn, lamps);
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'b1);
        btn_left  = 0;
        lamp_left = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
